axilite_noc_beat_packer: RTL and testbench

Packs a stream of narrow AXI-lite data beats into full-width NoC payload lines with valid/ready flow control on both sides. It sits directly upstream of the NoC-side width stage in the AXI-lite/NoC bridge. Beats are placed lane by lane, starting at lane 0, into a holding line. A line is emitted when it is full or when a beat marked last arrives. Throughput is one beat per cycle, including across line boundaries.

---
 rtl/axilite_noc_beat_packer.sv | 106 ++++++++++
 tb/tb_axilite_noc_beat_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_noc_beat_packer.sv
// rtl/axilite_noc_beat_packer.sv - packs narrow input beats into full-width output lines
module axilite_noc_beat_packer #(
    parameter int DATA_INPUT_WIDTH  = 64,
    parameter int DATA_OUTPUT_WIDTH = 512,
    parameter int RATIO             = DATA_OUTPUT_WIDTH / DATA_INPUT_WIDTH,
    parameter int CW                = $clog2(RATIO) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_INPUT_WIDTH-1:0]  in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_OUTPUT_WIDTH-1:0] out_data,
    output logic [CW-1:0]                out_count,
    output logic                         out_last
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                       state_q;
    logic [CW-1:0]                lane_idx_q;
    logic [CW-1:0]                lane_idx_d;
    logic [DATA_OUTPUT_WIDTH-1:0] line_q;
    logic                         out_valid_q;
    logic [CW-1:0]                out_count_q;
    logic                         out_last_q;
    logic                         beat_acc;
    logic                         line_acc;
    logic                         line_closes;

    // A line in HOLD can be replaced in the same cycle it leaves, so readiness follows out_ready there.
    assign in_ready    = !rst && ((state_q == FILL) || out_ready);
    assign beat_acc    = in_valid && in_ready;
    assign line_acc    = (state_q == HOLD) && out_ready;
    assign lane_idx_d  = lane_idx_q + CW'(1);
    assign line_closes = (lane_idx_d == CW'(RATIO)) || in_last;

    assign out_valid = out_valid_q;
    assign out_data  = line_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

    // Fill/hold sequencer: writes lanes, closes lines, and refills without a bubble on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            lane_idx_q  <= '0;
            line_q      <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (beat_acc) begin
                        line_q[lane_idx_q*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH] <= in_data;
                        if (line_closes) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                            out_count_q <= lane_idx_d;
                            out_last_q  <= in_last;
                            lane_idx_q  <= '0;
                        end else begin
                            lane_idx_q <= lane_idx_d;
                        end
                    end
                end
                HOLD: begin
                    if (line_acc) begin
                        if (beat_acc) begin
                            // New line starts with this beat in lane 0; the rest must read as zero.
                            line_q <= {{(DATA_OUTPUT_WIDTH-DATA_INPUT_WIDTH){1'b0}}, in_data};
                            if (in_last) begin
                                out_count_q <= CW'(1);
                                out_last_q  <= 1'b1;
                            end else begin
                                state_q     <= FILL;
                                out_valid_q <= 1'b0;
                                out_count_q <= '0;
                                out_last_q  <= 1'b0;
                                lane_idx_q  <= CW'(1);
                            end
                        end else begin
                            state_q     <= FILL;
                            line_q      <= '0;
                            out_valid_q <= 1'b0;
                            out_count_q <= '0;
                            out_last_q  <= 1'b0;
                            lane_idx_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_noc_beat_packer.sv
// tb/tb_axilite_noc_beat_packer.sv - self-checking bench for axilite_noc_beat_packer
module tb_axilite_noc_beat_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [3:0]   out_count;
    logic         out_last;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [511:0] data;
        logic [3:0]   count;
        logic         last;
    } line_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic        exp_ov;
    } vec_t;

    line_t        sb[$];
    vec_t         vec[$];
    logic         m_hold;
    int           m_lane;
    logic [511:0] m_line;

    axilite_noc_beat_packer #(
        .DATA_INPUT_WIDTH (64),
        .DATA_OUTPUT_WIDTH(512)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks handshakes at the negative edge and predicts lines into the scoreboard.
    always @(negedge clk) begin
        line_t e;
        logic  exp_rdy;
        if (rst) begin
            m_hold = 1'b0;
            m_lane = 0;
            m_line = '0;
            sb.delete();
        end else begin
            exp_rdy = !m_hold || out_ready;
            check("in_ready", {511'b0, in_ready}, {511'b0, exp_rdy});
            check("out_valid", {511'b0, out_valid}, {511'b0, m_hold});
            if (m_hold && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_line", 512'd1, 512'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_count", {508'b0, out_count}, {508'b0, e.count});
                    check("out_last", {511'b0, out_last}, {511'b0, e.last});
                end
                m_hold = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                m_line[m_lane*64 +: 64] = in_data;
                if (m_lane + 1 == 8 || in_last) begin
                    e.data  = m_line;
                    e.count = 4'(m_lane + 1);
                    e.last  = in_last;
                    sb.push_back(e);
                    m_hold = 1'b1;
                    m_line = '0;
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic l, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                check("beat_timeout", 512'd1, 512'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [63:0] d, input logic l, input logic ov);
        vec_t v;
        v.d = d;
        v.l = l;
        v.exp_ov = ov;
        vec.push_back(v);
    endtask

    task automatic run_vectors(output int total_stalls);
        int st;
        total_stalls = 0;
        for (int i = 0; i < vec.size(); i++) begin
            send_beat(vec[i].d, vec[i].l, st);
            total_stalls += st;
            check($sformatf("latency_ov[%0d]", i), {511'b0, out_valid}, {511'b0, vec[i].exp_ov});
        end
        vec.delete();
    endtask

    initial begin
        int st;
        int tot;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {511'b0, out_valid}, 512'd0);
        check("rst_out_data", out_data, 512'd0);
        check("rst_out_count", {508'b0, out_count}, 512'd0);
        check("rst_out_last", {511'b0, out_last}, 512'd0);
        check("rst_in_ready", {511'b0, in_ready}, 512'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {511'b0, in_ready}, 512'd1);

        // Full line 1..8 closed by last on the 8th beat.
        for (int k = 0; k < 8; k++) push_vec(64'(k + 1), k == 7, k == 7);
        run_vectors(tot);
        idle(3);

        // Partial line A,B,C.
        push_vec(64'hA, 1'b0, 1'b0);
        push_vec(64'hB, 1'b0, 1'b0);
        push_vec(64'hC, 1'b1, 1'b1);
        run_vectors(tot);
        idle(3);

        // 24 continuous beats, no last: three full lines with no stalls.
        for (int k = 0; k < 24; k++) push_vec(64'(k), 1'b0, (k % 8) == 7);
        run_vectors(tot);
        check("stream_stalls", 512'(tot), 512'd0);
        idle(3);

        // Back-pressure on a full line with a pending beat.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_beat(64'h100 + 64'(k), 1'b0, st);
        end
        in_valid = 1'b1;
        in_data  = 64'h200;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", {511'b0, in_ready}, 512'd0);
            if (sb.size() > 0) check("bp_out_data_stable", out_data, sb[0].data);
            else check("bp_line_missing", 512'd1, 512'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(64'h200, 1'b0, st);
        check("bp_refill_stall", 512'(st), 512'd0);
        for (int k = 1; k < 8; k++) send_beat(64'h200 + 64'(k), k == 7, st);
        idle(3);

        // Line accepted in the same cycle as a single last beat.
        out_ready = 1'b0;
        send_beat(64'h11, 1'b0, st);
        send_beat(64'h22, 1'b1, st);
        in_valid = 1'b1;
        in_data  = 64'h55;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check("same_cycle_out_valid", {511'b0, out_valid}, 512'd1);
        check("same_cycle_out_data", out_data, 512'h55);
        check("same_cycle_out_count", {508'b0, out_count}, 512'd1);
        check("same_cycle_out_last", {511'b0, out_last}, 512'd1);
        out_ready = 1'b1;
        idle(3);

        // Reset mid-line discards held beats.
        for (int k = 0; k < 4; k++) send_beat(64'h401 + 64'(k), 1'b0, st);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {511'b0, out_valid}, 512'd0);
        check("midrst_out_data", out_data, 512'd0);
        check("midrst_out_count", {508'b0, out_count}, 512'd0);
        check("midrst_in_ready", {511'b0, in_ready}, 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) push_vec(64'h301 + 64'(k), k == 7, k == 7);
        run_vectors(tot);
        idle(4);

        check("scoreboard_empty", 512'(sb.size()), 512'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
